uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter between NUM_REQ on-chip message sources (game engine,

---
 rtl/uart_tx_arbiter_if.sv | 27 ++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of signals between the message sources, the arbiter and the UART
// transmitter. The arbiter takes the slave view; the requester/UART side
// (or a bench standing in for it) takes the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   ack;
  logic [2:0]           grant_id;
  logic                 busy;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 err_timeout;

  modport master (
    output req, req_data, req_last, tx_busy,
    input  ack, grant_id, busy, tx_start, tx_data, err_timeout
  );

  modport slave (
    input  req, req_data, req_last, tx_busy,
    output ack, grant_id, busy, tx_start, tx_data, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ message
// sources. Ownership is held across a multi-byte message (ended by req_last)
// so messages never interleave on the wire. NUM_REQ must match the value
// the connected interface instance was built with.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic               clk,
  input logic               reset_pin,
  uart_tx_arbiter_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACC,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t         state_reg, state_next;
  logic [2:0]     grant_reg, grant_next;
  logic [2:0]     ptr_reg, ptr_next;
  logic           lock_reg, lock_next;
  logic [TW-1:0]  timer_reg, timer_next;
  logic [7:0]     tx_data_reg, tx_data_next;
  logic           err_reg, err_next;

  logic           found;
  logic [2:0]     winner;
  logic [7:0]     winner_data;
  logic           owner_req;
  logic           owner_last;
  logic [7:0]     owner_data;
  logic           timeout_hit;

  assign timeout_hit = (timer_reg == TW'(TIMEOUT_CYC - 1));

  // Round-robin search: first request at or after ptr, else wrap to the lowest.
  always_comb begin
    found       = 1'b0;
    winner      = ptr_reg;
    winner_data = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[k] && (3'(k) >= ptr_reg)) begin
        found       = 1'b1;
        winner      = 3'(k);
        winner_data = bus.req_data[8*k +: 8];
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && bus.req[k]) begin
        found       = 1'b1;
        winner      = 3'(k);
        winner_data = bus.req_data[8*k +: 8];
      end
    end
  end

  // Current owner's request lines, picked out by the registered grant.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_reg == 3'(k)) begin
        owner_req  = bus.req[k];
        owner_last = bus.req_last[k];
        owner_data = bus.req_data[8*k +: 8];
      end
    end
  end

  // Next-state logic; the timer only runs while dwelling in WAIT_ACC or HOLD.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    ptr_next     = ptr_reg;
    lock_next    = lock_reg;
    tx_data_next = tx_data_reg;
    err_next     = 1'b0;
    timer_next   = '0;
    case (state_reg)
      IDLE: begin
        if (found) begin
          grant_next   = winner;
          tx_data_next = winner_data;
          state_next   = LOAD;
        end
      end
      LOAD: begin
        lock_next  = ~owner_last;
        ptr_next   = (grant_reg == 3'(NUM_REQ - 1)) ? 3'd0 : grant_reg + 3'd1;
        state_next = WAIT_ACC;
      end
      WAIT_ACC: begin
        if (bus.tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timeout_hit) begin
          err_next   = 1'b1;
          lock_next  = 1'b0;
          state_next = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_next = lock_reg ? HOLD : IDLE;
        end
      end
      HOLD: begin
        // A timeout beats a same-cycle re-request from the owner.
        if (timeout_hit) begin
          err_next   = 1'b1;
          lock_next  = 1'b0;
          state_next = IDLE;
        end else if (owner_req) begin
          tx_data_next = owner_data;
          state_next   = LOAD;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset_pin) begin
      state_reg   <= IDLE;
      grant_reg   <= 3'd0;
      ptr_reg     <= 3'd0;
      lock_reg    <= 1'b0;
      timer_reg   <= '0;
      tx_data_reg <= 8'h00;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      lock_reg    <= lock_next;
      timer_reg   <= timer_next;
      tx_data_reg <= tx_data_next;
      err_reg     <= err_next;
    end
  end

  assign bus.busy        = (state_reg != IDLE);
  assign bus.tx_start    = (state_reg == LOAD);
  assign bus.grant_id    = grant_reg;
  assign bus.tx_data     = tx_data_reg;
  assign bus.err_timeout = err_reg;

  // Ack is a one-cycle pulse to the owner during LOAD.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
      assign bus.ack[gi] = (state_reg == LOAD) && (grant_reg == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART frame model.
module tb_uart_tx_arbiter;

  localparam int N         = 4;
  localparam int TMO       = 1024;
  localparam int FRAME_LEN = 8;

  logic clk = 1'b0;
  logic reset_pin;
  int   total = 0;
  int   bad   = 0;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk       (clk),
    .reset_pin (reset_pin),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // UART model: takes a byte on tx_start, stays busy for FRAME_LEN cycles.
  logic       uart_en   = 1'b1;
  logic       uart_busy = 1'b0;
  int         uart_cnt  = 0;
  logic [7:0] wire_log[$];
  int         ack_cnt[N];

  assign bus.tx_busy = uart_busy;

  always @(negedge clk) begin
    if (uart_cnt > 0) begin
      uart_cnt <= uart_cnt - 1;
      if (uart_cnt == 1) uart_busy <= 1'b0;
    end else if (uart_en && bus.tx_start === 1'b1) begin
      wire_log.push_back(bus.tx_data);
      uart_busy <= 1'b1;
      uart_cnt  <= FRAME_LEN;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++)
      if (bus.ack[i] === 1'b1) ack_cnt[i] <= ack_cnt[i] + 1;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a start strobe, then check the grant it carries.
  task automatic serve(input int id, input logic [7:0] exp_byte, input int budget);
    int n;
    n = 0;
    while (bus.tx_start !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("start_seen", 32'(bus.tx_start), 32'd1);
    check("grant_id", 32'(bus.grant_id), 32'(id));
    check("ack", 32'(bus.ack), 32'd1 << id);
    check("tx_data", 32'(bus.tx_data), 32'(exp_byte));
    check("busy_in_load", 32'(bus.busy), 32'd1);
    tick();
    check("pulse_width", 32'({bus.tx_start, bus.ack}), 32'd0);
  endtask

  task automatic wait_busy_low(input int budget);
    int n;
    n = 0;
    while (bus.tx_busy !== 1'b0 && n < budget) begin
      tick();
      n++;
    end
    check("tx_busy_fall", 32'(bus.tx_busy), 32'd0);
  endtask

  task automatic check_wire(input logic [7:0] exp);
    logic [31:0] got;
    got = 32'hFFFF_FFFF;
    if (wire_log.size() > 0) got = 32'(wire_log.pop_front());
    check("wire_byte", got, 32'(exp));
  endtask

  task automatic wait_err(input int budget, output int n);
    n = 0;
    while (bus.err_timeout !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int base[N];
    int n;

    reset_pin    = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    repeat (3) tick();

    // Reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_start", 32'(bus.tx_start), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_err", 32'(bus.err_timeout), 32'd0);
    check("rst_grant", 32'(bus.grant_id), 32'd0);
    check("rst_data", 32'(bus.tx_data), 32'd0);
    reset_pin = 1'b0;
    tick();

    // T2 single byte, start exactly one cycle after req
    bus.req[2] = 1'b1;
    bus.req_data[8*2 +: 8] = 8'hA5;
    bus.req_last[2] = 1'b1;
    tick();
    serve(2, 8'hA5, 0);
    bus.req[2] = 1'b0;
    wait_busy_low(50);
    check("busy_before_drop", 32'(bus.busy), 32'd1);
    tick();
    check("busy_after_drop", 32'(bus.busy), 32'd0);
    check_wire(8'hA5);

    // T1 reset in WAIT_DONE after serving req[1]; ptr must return to 0
    bus.req[1] = 1'b1;
    bus.req_data[8*1 +: 8] = 8'h3C;
    bus.req_last[1] = 1'b1;
    serve(1, 8'h3C, 5);
    bus.req[1] = 1'b0;
    repeat (2) tick();
    check("t1_busy_wait_done", 32'(bus.busy), 32'd1);
    reset_pin = 1'b1;
    repeat (3) tick();
    check("t1_rst_outputs", 32'({bus.busy, bus.tx_start, bus.ack, bus.err_timeout, bus.grant_id, bus.tx_data}), 32'd0);
    reset_pin = 1'b0;
    wait_busy_low(50);
    check_wire(8'h3C);
    tick();

    // T3 round robin with all requesters held, single-byte messages
    for (int i = 0; i < N; i++) base[i] = ack_cnt[i];
    bus.req = 4'b1111;
    bus.req_last = 4'b1111;
    bus.req_data = {8'h33, 8'h32, 8'h31, 8'h30};
    serve(0, 8'h30, 40);
    serve(1, 8'h31, 40);
    serve(2, 8'h32, 40);
    serve(3, 8'h33, 40);
    serve(0, 8'h30, 40);
    bus.req = '0;
    bus.req_last = '0;
    wait_busy_low(50);
    tick();
    for (int i = 0; i < N; i++)
      check("t3_ack_count", 32'(ack_cnt[i] - base[i]), (i == 0) ? 32'd2 : 32'd1);
    check_wire(8'h30);
    check_wire(8'h31);
    check_wire(8'h32);
    check_wire(8'h33);
    check_wire(8'h30);

    // T4 locked 3-byte message from req[1] while req[0] waits
    for (int i = 0; i < N; i++) base[i] = ack_cnt[i];
    bus.req[0] = 1'b1;
    bus.req_data[8*0 +: 8] = 8'h40;
    bus.req_last[0] = 1'b1;
    bus.req[1] = 1'b1;
    bus.req_data[8*1 +: 8] = 8'h11;
    bus.req_last[1] = 1'b0;
    serve(1, 8'h11, 10);
    bus.req_data[8*1 +: 8] = 8'h22;
    wait_busy_low(50);
    tick();
    check("t4_gap_start", 32'(bus.tx_start), 32'd0);
    tick();
    serve(1, 8'h22, 0);
    bus.req_data[8*1 +: 8] = 8'h33;
    bus.req_last[1] = 1'b1;
    serve(1, 8'h33, 40);
    bus.req[1] = 1'b0;
    check("t4_req0_blocked", 32'(ack_cnt[0] - base[0]), 32'd0);
    serve(0, 8'h40, 40);
    bus.req[0] = 1'b0;
    wait_busy_low(50);
    tick();
    check_wire(8'h11);
    check_wire(8'h22);
    check_wire(8'h33);
    check_wire(8'h40);

    // T5 UART never accepts: timeout after TMO cycles in WAIT_ACC
    uart_en = 1'b0;
    bus.req[3] = 1'b1;
    bus.req_data[8*3 +: 8] = 8'h5A;
    bus.req_last[3] = 1'b1;
    bus.req[0] = 1'b1;
    bus.req_data[8*0 +: 8] = 8'h60;
    serve(3, 8'h5A, 10);
    bus.req[3] = 1'b0;
    wait_err(2000, n);
    check("t5_err_delay", 32'(n), 32'(TMO));
    check("t5_idle_at_err", 32'(bus.busy), 32'd0);
    uart_en = 1'b1;
    tick();
    check("t5_err_pulse", 32'(bus.err_timeout), 32'd0);
    serve(0, 8'h60, 10);
    bus.req[0] = 1'b0;
    wait_busy_low(50);
    tick();
    check_wire(8'h60);

    // T6 owner abandons a message in HOLD; others proceed after timeout
    for (int i = 0; i < N; i++) base[i] = ack_cnt[i];
    bus.req[1] = 1'b1;
    bus.req_data[8*1 +: 8] = 8'h71;
    bus.req_last[1] = 1'b0;
    bus.req[2] = 1'b1;
    bus.req_data[8*2 +: 8] = 8'h72;
    bus.req_last[2] = 1'b1;
    serve(1, 8'h71, 10);
    bus.req[1] = 1'b0;
    wait_busy_low(50);
    wait_err(2000, n);
    check("t6_hold_err_delay", 32'(n), 32'(TMO + 1));
    check("t6_req2_blocked", 32'(ack_cnt[2] - base[2]), 32'd0);
    serve(2, 8'h72, 10);
    bus.req[2] = 1'b0;
    wait_busy_low(50);
    tick();
    check_wire(8'h71);
    check_wire(8'h72);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
